// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Conditions NUM_BTN raw push-button / DIP pins. Each bit is
//                passed through a 2-flop synchroniser, polarity-normalised
//                (1 = pressed) and debounced by a per-channel FSM clocked by a
//                1 ms tick. Emits a clean level plus single-cycle press,
//                release and long-press pulses.
//  Ports       : clk_i         system clock
//                rstn_i        asynchronous active-low reset
//                btn_pin_i     raw asynchronous button pins
//                btn_level_o   debounced level, 1 = pressed
//                btn_press_o   1-cycle pulse when a press is accepted
//                btn_release_o 1-cycle pulse when a release is accepted
//                btn_long_o    1-cycle pulse once per press after LONG_PRESS_MS
//  Notes       : FAST_TICK=1 (or SIM defined) ties the tick high so every
//                clock counts as one millisecond.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int   CLK_IN_MHZ    = 125,
    parameter int   NUM_BTN       = 4,
    parameter logic BTN_POLARITY  = 1'b0,
    parameter int   DEBOUNCE_MS   = 20,
    parameter int   LONG_PRESS_MS = 1000,
    parameter bit   FAST_TICK     = 1'b0
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NUM_BTN-1:0] btn_pin_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic [NUM_BTN-1:0] btn_long_o
);

    localparam int C_PRESC_CNT = CLK_IN_MHZ * 1000;
    localparam int C_PRESC_W   = (C_PRESC_CNT > 1) ? $clog2(C_PRESC_CNT) : 1;
    localparam int C_DEB_W     = $clog2(DEBOUNCE_MS + 1);
    localparam int C_LONG_W    = $clog2(LONG_PRESS_MS + 1);

    localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(C_PRESC_CNT - 1);
    localparam logic [C_DEB_W-1:0]   C_DEB_MAX   = C_DEB_W'(DEBOUNCE_MS);
    localparam logic [C_LONG_W-1:0]  C_LONG_MAX  = C_LONG_W'(LONG_PRESS_MS);
    localparam logic [NUM_BTN-1:0]   C_RELEASED  = {NUM_BTN{~BTN_POLARITY}};

`ifdef SIM
    localparam bit C_FAST_TICK = 1'b1;
`else
    localparam bit C_FAST_TICK = FAST_TICK;
`endif

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // 1 ms tick prescaler
    // ------------------------------------------------------------------
    logic [C_PRESC_W-1:0] r_presc;
    logic                 w_presc_tc;
    logic                 w_tick;

    assign w_presc_tc = (r_presc == C_PRESC_MAX);
    assign w_tick     = C_FAST_TICK | w_presc_tc;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_presc <= '0;
        end else if (w_presc_tc) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + C_PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Synchroniser. Flops reset to the released pin level so that reset
    // deassertion cannot look like a press edge.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] w_s;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync1 <= C_RELEASED;
            r_sync2 <= C_RELEASED;
        end else begin
            r_sync1 <= btn_pin_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ C_RELEASED;

    // ------------------------------------------------------------------
    // Per-channel debounce FSM
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_t              r_state;
        state_t              w_state_nxt;
        logic [C_DEB_W-1:0]  r_deb;
        logic [C_DEB_W-1:0]  w_deb_nxt;
        logic [C_DEB_W-1:0]  w_deb_inc;
        logic [C_LONG_W-1:0] r_long;
        logic [C_LONG_W-1:0] w_long_nxt;
        logic [C_LONG_W-1:0] w_long_inc;
        logic                r_level;
        logic                r_press;
        logic                r_rel;
        logic                r_lp;
        logic                w_level_nxt;
        logic                w_press_nxt;
        logic                w_rel_nxt;
        logic                w_lp_nxt;

        assign w_deb_inc  = r_deb + C_DEB_W'(1);
        assign w_long_inc = r_long + C_LONG_W'(1);

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_state <= S_RELEASED;
                r_deb   <= '0;
                r_long  <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_lp    <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_deb   <= w_deb_nxt;
                r_long  <= w_long_nxt;
                r_level <= w_level_nxt;
                r_press <= w_press_nxt;
                r_rel   <= w_rel_nxt;
                r_lp    <= w_lp_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_deb_nxt   = r_deb;
            w_long_nxt  = r_long;
            w_level_nxt = r_level;
            w_press_nxt = 1'b0;
            w_rel_nxt   = 1'b0;
            w_lp_nxt    = 1'b0;

            // Hold timer runs whenever the committed level is "pressed";
            // saturation makes the long pulse fire only once per press.
            if ((r_state == S_PRESSED || r_state == S_RELEASE_PEND) &&
                w_tick && (r_long != C_LONG_MAX)) begin
                w_long_nxt = w_long_inc;
                w_lp_nxt   = (w_long_inc == C_LONG_MAX);
            end

            case (r_state)
                S_RELEASED: begin
                    if (w_s[g]) begin
                        w_state_nxt = S_PRESS_PEND;
                        w_deb_nxt   = '0;
                    end
                end
                S_PRESS_PEND: begin
                    if (!w_s[g]) begin
                        w_state_nxt = S_RELEASED;
                        w_deb_nxt   = '0;
                    end else if (w_tick) begin
                        if (w_deb_inc == C_DEB_MAX) begin
                            w_state_nxt = S_PRESSED;
                            w_deb_nxt   = '0;
                            w_level_nxt = 1'b1;
                            w_press_nxt = 1'b1;
                            w_long_nxt  = '0;
                        end else begin
                            w_deb_nxt   = w_deb_inc;
                        end
                    end
                end
                S_PRESSED: begin
                    if (!w_s[g]) begin
                        w_state_nxt = S_RELEASE_PEND;
                        w_deb_nxt   = '0;
                    end
                end
                S_RELEASE_PEND: begin
                    if (w_s[g]) begin
                        w_state_nxt = S_PRESSED;
                        w_deb_nxt   = '0;
                    end else if (w_tick) begin
                        if (w_deb_inc == C_DEB_MAX) begin
                            // A release committing on the long-press tick
                            // suppresses the long pulse.
                            w_state_nxt = S_RELEASED;
                            w_deb_nxt   = '0;
                            w_level_nxt = 1'b0;
                            w_rel_nxt   = 1'b1;
                            w_long_nxt  = '0;
                            w_lp_nxt    = 1'b0;
                        end else begin
                            w_deb_nxt   = w_deb_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_RELEASED;
                    w_deb_nxt   = '0;
                    w_long_nxt  = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

        assign btn_level_o[g]   = r_level;
        assign btn_press_o[g]   = r_press;
        assign btn_release_o[g] = r_rel;
        assign btn_long_o[g]    = r_lp;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Directed self-checking bench for btn_debounce with the tick
//                running every clock, DEBOUNCE_MS=4, LONG_PRESS_MS=10.
//                Pin edge driven just after clock N commits at clock N+7.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_debounce;

    localparam int NB = 4;

    logic          clk;
    logic          rstn;
    logic [NB-1:0] pins;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] lng;

    btn_debounce #(
        .CLK_IN_MHZ    (125),
        .NUM_BTN       (NB),
        .BTN_POLARITY  (1'b0),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (10),
        .FAST_TICK     (1'b1)
    ) u_dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .btn_pin_i     (pins),
        .btn_level_o   (level),
        .btn_press_o   (press),
        .btn_release_o (rel),
        .btn_long_o    (lng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge
    int            press_cnt [NB];
    int            press_cyc [NB];
    int            rel_cnt   [NB];
    int            rel_cyc   [NB];
    int            long_cnt  [NB];
    int            long_cyc  [NB];
    int            rise_cyc  [NB];
    logic [NB-1:0] level_seen;
    logic [NB-1:0] prev_level;
    int            both_cnt;

    int n_chk = 0;
    int n_err = 0;

    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (press[b]) begin press_cnt[b]++; press_cyc[b] = cyc; end
            if (rel[b])   begin rel_cnt[b]++;   rel_cyc[b]   = cyc; end
            if (lng[b])   begin long_cnt[b]++;  long_cyc[b]  = cyc; end
            if (press[b] && rel[b]) both_cnt++;
            if (level[b]) level_seen[b] = 1'b1;
            if (level[b] && !prev_level[b]) rise_cyc[b] = cyc;
        end
        prev_level = level;
    end

    task automatic clear_log();
        for (int b = 0; b < NB; b++) begin
            press_cnt[b] = 0; press_cyc[b] = -1;
            rel_cnt[b]   = 0; rel_cyc[b]   = -1;
            long_cnt[b]  = 0; long_cyc[b]  = -1;
            rise_cyc[b]  = -1;
        end
        level_seen = '0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int b = 0; b < NB; b++) s += press_cnt[b] + rel_cnt[b] + long_cnt[b];
        return s;
    endfunction

    int n0, n2, n3, m;

    initial begin
        both_cnt   = 0;
        prev_level = '0;
        clear_log();
        rstn = 1'b0;
        pins = 4'hF;

        // Reset state
        tick_n(3);
        check("rst_outputs", {16'd0, level, press, rel, lng}, 32'd0);
        rstn = 1'b1;
        clear_log();
        tick_n(50);
        check("idle_level", {28'd0, level_seen}, 32'd0);
        check("idle_pulses", total_pulses(), 0);

        // Pin0 clean press then release
        clear_log();
        n0 = cyc;
        pins[0] = 1'b0;
        tick_n(8);
        check("p0_press_cnt", press_cnt[0], 1);
        check("p0_press_cyc", press_cyc[0], n0 + 7);
        check("p0_level_rise", rise_cyc[0], n0 + 7);
        check("p0_level_now", {31'd0, level[0]}, 32'd1);
        pins[0] = 1'b1;
        tick_n(10);
        check("p0_rel_cnt", rel_cnt[0], 1);
        check("p0_rel_cyc", rel_cyc[0], n0 + 15);
        check("p0_long_cnt", long_cnt[0], 0);
        check("p0_level_end", {31'd0, level[0]}, 32'd0);

        // Pin1 bouncing every 2 cycles
        clear_log();
        for (int i = 0; i < 20; i++) begin
            pins[1] = ~pins[1];
            tick_n(2);
        end
        tick_n(10);
        check("p1_level_seen", {31'd0, level_seen[1]}, 32'd0);
        check("p1_pulses", total_pulses(), 0);

        // Pin2 long hold
        clear_log();
        n2 = cyc;
        pins[2] = 1'b0;
        tick_n(20);
        pins[2] = 1'b1;
        tick_n(12);
        check("p2_press_cyc", press_cyc[2], n2 + 7);
        check("p2_long_cnt", long_cnt[2], 1);
        check("p2_long_cyc", long_cyc[2], n2 + 17);
        check("p2_rel_cnt", rel_cnt[2], 1);
        check("p2_rel_cyc", rel_cyc[2], n2 + 27);

        // Pin3 release committing on the 10th hold tick
        clear_log();
        n3 = cyc;
        pins[3] = 1'b0;
        tick_n(10);
        pins[3] = 1'b1;
        tick_n(12);
        check("p3_press_cyc", press_cyc[3], n3 + 7);
        check("p3_rel_cnt", rel_cnt[3], 1);
        check("p3_rel_cyc", rel_cyc[3], n3 + 17);
        check("p3_long_cnt", long_cnt[3], 0);

        // Async reset mid-debounce of pin0 while pin3 is held pressed
        clear_log();
        pins[3] = 1'b0;
        tick_n(8);
        m = cyc;
        pins[0] = 1'b0;
        tick_n(4);
        check("pre_rst_level3", {31'd0, level[3]}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_out", {16'd0, level, press, rel, lng}, 32'd0);
        pins = 4'hF;
        tick_n(3);
        rstn = 1'b1;
        clear_log();
        tick_n(20);
        check("post_rst_pulses", total_pulses(), 0);
        check("post_rst_level", {28'd0, level_seen}, 32'd0);
        check("no_press_and_rel", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
